sprite_palette_ram: RTL

//  Runtime-writable, multi-palette colour lookup for character sprites; successor to the fixed per-character ROM palettes.

---
 rtl/sprite_palette_ram_if.sv | 38 +++
 rtl/sprite_palette_ram.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_ram_if.sv
// Bus bundle for the sprite palette RAM: lookup request/response, palette
// write port and hit-flash control. The master drives requests, the slave
// (the palette RAM) returns looked-up colours and the flash status.
interface sprite_palette_ram_if #(
    parameter int IDX_W   = 4,
    parameter int COLOR_W = 4,
    parameter int NUM_PAL = 4
);
    localparam int PAL_W = $clog2(NUM_PAL);

    logic                   frame_start;
    logic                   rd_valid;
    logic [PAL_W-1:0]       rd_pal;
    logic [IDX_W-1:0]       rd_index;
    logic                   out_valid;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   transparent;
    logic                   wr_en;
    logic [PAL_W-1:0]       wr_pal;
    logic [IDX_W-1:0]       wr_index;
    logic [3*COLOR_W-1:0]   wr_rgb;
    logic                   flash_start;
    logic                   flash_active;

    modport master (
        output frame_start, rd_valid, rd_pal, rd_index,
        output wr_en, wr_pal, wr_index, wr_rgb, flash_start,
        input  out_valid, red, green, blue, transparent, flash_active
    );

    modport slave (
        input  frame_start, rd_valid, rd_pal, rd_index,
        input  wr_en, wr_pal, wr_index, wr_rgb, flash_start,
        output out_valid, red, green, blue, transparent, flash_active
    );
endinterface

// File: rtl/sprite_palette_ram.sv
// Runtime-writable multi-palette colour lookup for character sprites.
// Two-stage lookup pipeline (RAM read, then transparency/flash shaping),
// read-first palette RAM, and a frame-synchronised hit-flash FSM that turns
// opaque pixels white on even frames of the flash.
module sprite_palette_ram #(
    parameter int IDX_W        = 4,
    parameter int COLOR_W      = 4,
    parameter int NUM_PAL      = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    sprite_palette_ram_if.slave   bus
);
    localparam int PAL_W  = $clog2(NUM_PAL);
    localparam int ADDR_W = PAL_W + IDX_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int RGB_W  = 3 * COLOR_W;
    localparam int FCNT_W = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FLASHING = 2'd2
    } flash_state_e;

    // Palette storage, addressed {pal, index}; never cleared by reset.
    logic [RGB_W-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] wr_addr_s;

    // Stage 1 registers
    logic              s1_valid_q, s1_valid_d;
    logic              s1_transp_q, s1_transp_d;
    logic [RGB_W-1:0]  s1_rgb_q;

    // Stage 2 (output) registers
    logic              out_valid_q, out_valid_d;
    logic              transparent_q, transparent_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              flash_white_s;

    // Flash FSM registers
    flash_state_e      state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              flash_active_q, flash_active_d;

    assign rd_addr_s = {bus.rd_pal, bus.rd_index};
    assign wr_addr_s = {bus.wr_pal, bus.wr_index};

    // Palette RAM: write port plus registered read; the read samples the array before this edge's write lands (read-first).
    always_ff @(posedge Clk) begin
        if (bus.wr_en) begin
            mem_q[wr_addr_s] <= bus.wr_rgb;
        end
        s1_rgb_q <= mem_q[rd_addr_s];
    end

    // Stage 1 control: carry the request valid and the transparency flag alongside the RAM read.
    always_comb begin
        s1_valid_d  = bus.rd_valid;
        s1_transp_d = bus.rd_valid && (bus.rd_index == IDX_W'(TRANSP_IDX));
    end

    // Stage 2: shape the RAM word; transparency wins over flash, outputs hold when no lookup arrives.
    always_comb begin
        flash_white_s = (state_q == ST_FLASHING) && (fcnt_q[0] == 1'b0);
        out_valid_d   = s1_valid_q;
        transparent_d = transparent_q;
        rgb_d         = rgb_q;
        if (s1_valid_q) begin
            if (s1_transp_q) begin
                transparent_d = 1'b1;
                rgb_d         = {RGB_W{1'b0}};
            end else if (flash_white_s) begin
                transparent_d = 1'b0;
                rgb_d         = {RGB_W{1'b1}};
            end else begin
                transparent_d = 1'b0;
                rgb_d         = s1_rgb_q;
            end
        end else begin
            transparent_d = transparent_q;
            rgb_d         = rgb_q;
        end
    end

    // Flash FSM next state: a new request while flashing re-arms so the flash restarts on the next frame.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flash_start) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (bus.frame_start) begin
                    state_d = ST_FLASHING;
                    fcnt_d  = {FCNT_W{1'b0}};
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_FLASHING: begin
                if (bus.flash_start) begin
                    state_d = ST_ARMED;
                end else if (bus.frame_start) begin
                    if (fcnt_q == FCNT_W'(FLASH_FRAMES - 1)) begin
                        state_d = ST_IDLE;
                        fcnt_d  = {FCNT_W{1'b0}};
                    end else begin
                        fcnt_d  = fcnt_q + FCNT_W'(1);
                    end
                end else begin
                    state_d = ST_FLASHING;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = {FCNT_W{1'b0}};
            end
        endcase
        flash_active_d = (state_d == ST_FLASHING);
    end

    // State register for pipeline and FSM; reset discards in-flight lookups and cancels any flash.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q     <= 1'b0;
            s1_transp_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            transparent_q  <= 1'b0;
            rgb_q          <= {RGB_W{1'b0}};
            state_q        <= ST_IDLE;
            fcnt_q         <= {FCNT_W{1'b0}};
            flash_active_q <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_transp_q    <= s1_transp_d;
            out_valid_q    <= out_valid_d;
            transparent_q  <= transparent_d;
            rgb_q          <= rgb_d;
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            flash_active_q <= flash_active_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.transparent  = transparent_q;
    assign bus.red          = rgb_q[RGB_W-1 -: COLOR_W];
    assign bus.green        = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue         = rgb_q[COLOR_W-1:0];
    assign bus.flash_active = flash_active_q;
endmodule
